// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler
// Sequences the select lines of an external combinational 4:1 selector,
// waits SETTLE_CYCLES on each enabled channel, captures the returned bit
// and publishes one 4-bit snapshot per scan.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no scan in progress; waiting for start with a non-zero mask
// SETTLE | sel driven on a channel, counting down to its capture edge
//
// SETTLE_CYCLES legal range is 1..256 (8-bit dwell counter).

module mux_scan_sampler #(
    parameter int SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       abort,
    input  logic [3:0] en_mask,
    input  logic       f_in,
    output logic [1:0] sel,
    output logic [3:0] sample,
    output logic       sample_valid,
    output logic       busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // Counter value on the edge where the channel's bit is captured.
    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] shadow_q, shadow_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] sample_q, sample_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;

    logic [3:0] above_sel;
    logic [3:0] remaining;
    logic [3:0] capture;

    // Lowest-numbered set bit of a channel mask (0 when the mask is empty).
    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        logic [1:0] ch;
        ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) begin
                ch = 2'(i);
            end
        end
        return ch;
    endfunction

    // Channels above the current one that are still to be visited, and the
    // shadow value including the bit being captured on this edge.
    always_comb begin
        above_sel        = 4'b1110 << sel_q;
        remaining        = mask_q & above_sel;
        capture          = shadow_q;
        capture[sel_q]   = f_in;
    end

    // Next-state and datapath decisions; abort outranks every other event.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        sel_d    = sel_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            IDLE: begin
                if (!abort && start && (en_mask != 4'd0)) begin
                    mask_d   = en_mask;
                    shadow_d = 4'd0;
                    sel_d    = lowest_ch(en_mask);
                    cnt_d    = 8'd0;
                    busy_d   = 1'b1;
                    state_d  = SETTLE;
                end
            end

            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    sel_d   = 2'd0;
                    cnt_d   = 8'd0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    shadow_d = capture;
                    cnt_d    = 8'd0;
                    if (remaining != 4'd0) begin
                        sel_d = lowest_ch(remaining);
                    end else begin
                        sample_d = capture;
                        valid_d  = 1'b1;
                        if (continuous && (en_mask != 4'd0)) begin
                            mask_d   = en_mask;
                            shadow_d = 4'd0;
                            sel_d    = lowest_ch(en_mask);
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            mask_q   <= 4'd0;
            shadow_q <= 4'd0;
            sel_q    <= 2'd0;
            sample_q <= 4'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            sel_q    <= sel_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign sel          = sel_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler: a behavioural 4:1 selector feeds f_in from a
// word w, and each scan's expected timeline is derived from the list of
// enabled channels and the dwell length.

module tb_mux_scan_sampler;

    localparam int S = 3;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       start      = 1'b0;
    logic       continuous = 1'b0;
    logic       abort      = 1'b0;
    logic [3:0] en_mask    = 4'd0;
    logic [3:0] w          = 4'd0;
    logic       f_in;
    logic [1:0] sel;
    logic [3:0] sample;
    logic       sample_valid;
    logic       busy;

    int         n_assert   = 0;
    int         n_fail     = 0;
    logic [3:0] exp_sample = 4'd0;
    logic [1:0] exp_sel    = 2'd0;

    always #5 clk = ~clk;

    assign f_in = w[sel];

    mux_scan_sampler #(.SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .continuous   (continuous),
        .abort        (abort),
        .en_mask      (en_mask),
        .f_in         (f_in),
        .sel          (sel),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},  8'(busy), 8'd0);
        chk({tag, "_valid"}, 8'(sample_valid), 8'd0);
        chk({tag, "_sel"},   8'(sel), 8'(exp_sel));
        chk({tag, "_sample"}, 8'(sample), 8'(exp_sample));
    endtask

    // One single-shot scan of mask m. With noise set, w, start and en_mask
    // are scrambled every cycle; only w at each capture edge may matter.
    task automatic scan(input logic [3:0] m, input bit noise, input string tag);
        int         chs[$];
        int         n;
        logic [3:0] expv;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) chs.push_back(i);
        end
        n       = chs.size();
        expv    = 4'd0;
        en_mask = m;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < n * S; j++) begin
            chk({tag, "_sel"},   8'(sel), 8'(chs[j / S]));
            chk({tag, "_busy"},  8'(busy), 8'd1);
            chk({tag, "_valid"}, 8'(sample_valid), 8'd0);
            if (noise) begin
                w = 4'($urandom);
                if (j < n * S - 1) begin
                    start   = 1'($urandom);
                    en_mask = 4'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
            if ((j + 1) % S == 0) expv[chs[j / S]] = w[chs[j / S]];
            tick();
        end
        start = 1'b0;
        chk({tag, "_pulse"},  8'(sample_valid), 8'd1);
        chk({tag, "_sample"}, 8'(sample), 8'(expv));
        chk({tag, "_done"},   8'(busy), 8'd0);
        chk({tag, "_selhold"}, 8'(sel), 8'(chs[n - 1]));
        exp_sample = expv;
        exp_sel    = 2'(chs[n - 1]);
        tick();
        check_idle({tag, "_after"});
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sel",    8'(sel), 8'd0);
        chk("rst_sample", 8'(sample), 8'd0);
        chk("rst_valid",  8'(sample_valid), 8'd0);
        chk("rst_busy",   8'(busy), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle("idle0");

        // Full and sparse scans with the fixed selector pattern.
        w = 4'b1101;
        scan(4'b1111, 1'b0, "full");
        scan(4'b0101, 1'b0, "sparse");

        // start with an empty mask is ignored.
        en_mask = 4'd0;
        start   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_idle("empty");
        end
        start = 1'b0;

        // Randomized scans with scrambled inputs during the dwell.
        for (int k = 0; k < 6; k++) begin
            w = 4'($urandom);
            scan(4'($urandom_range(1, 15)), 1'b1, "rnd");
        end

        // Continuous: mask change mid-scan applies only to the next scan.
        w          = 4'b1101;
        continuous = 1'b1;
        en_mask    = 4'b1111;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 4 * S; j++) begin
            chk("cont1_sel",   8'(sel), 8'(j / S));
            chk("cont1_busy",  8'(busy), 8'd1);
            chk("cont1_valid", 8'(sample_valid), 8'd0);
            if (j == 4) en_mask = 4'b0010;
            tick();
        end
        chk("cont1_pulse",  8'(sample_valid), 8'd1);
        chk("cont1_sample", 8'(sample), 8'b1101);
        continuous = 1'b0;
        for (int j = 0; j < S; j++) begin
            chk("cont2_sel",  8'(sel), 8'd1);
            chk("cont2_busy", 8'(busy), 8'd1);
            if (j > 0) chk("cont2_valid", 8'(sample_valid), 8'd0);
            tick();
        end
        chk("cont2_pulse",  8'(sample_valid), 8'd1);
        chk("cont2_sample", 8'(sample), 8'b0000);
        chk("cont2_done",   8'(busy), 8'd0);
        exp_sample = 4'b0000;
        exp_sel    = 2'd1;
        tick();
        check_idle("cont_after");

        // Non-zero snapshot to be retained across aborts.
        w = 4'b1011;
        scan(4'b1111, 1'b0, "pre");

        // Abort while dwelling on channel 2.
        w       = 4'($urandom);
        en_mask = 4'b1111;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j <= 2 * S; j++) tick();
        chk("abort_presel", 8'(sel), 8'd2);
        abort = 1'b1;
        tick();
        abort   = 1'b0;
        exp_sel = 2'd0;
        check_idle("abort_mid");
        tick();
        check_idle("abort_mid2");

        // Abort coincident with the final capture.
        en_mask = 4'b0001;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < S - 1; j++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_final");
        tick();
        check_idle("abort_final2");

        // Abort outranks start in IDLE.
        abort   = 1'b1;
        start   = 1'b1;
        en_mask = 4'b1111;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check_idle("abort_idle");
        tick();
        check_idle("abort_idle2");

        // Reset in the middle of a scan clears everything immediately.
        w       = 4'($urandom);
        en_mask = 4'b1111;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_sel",    8'(sel), 8'd0);
        chk("rstmid_sample", 8'(sample), 8'd0);
        chk("rstmid_valid",  8'(sample_valid), 8'd0);
        chk("rstmid_busy",   8'(busy), 8'd0);
        exp_sample = 4'd0;
        exp_sel    = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle("rstmid_after");

        w = 4'($urandom);
        scan(4'($urandom_range(1, 15)), 1'b1, "post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_sampler.md
Name: mux_scan_sampler

Overview:
- Sequencer that sits directly upstream and downstream of the 4:1 selector.
- Drives the 2-bit select, waits a programmable settle time per channel, and samples the selector's 1-bit output.
- Assembles one 4-bit snapshot per scan of the enabled channels.
- Supports single-shot and continuous scanning, with abort.

Parameters:
SETTLE_CYCLES, 3, cycles sel is held on a channel before f_in is captured; legal range 1..256; counter is 8 bits.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level-sampled; begins a scan when idle
continuous  input  1  when 1, a new scan starts automatically after each completed scan
abort  input  1  synchronous; terminates the scan in progress
en_mask  input  4  channel enable, bit i = channel i; latched at each scan start
f_in  input  1  selected data bit returned from the 4:1 selector
sel  output  2  channel select driven to the 4:1 selector, registered
sample  output  4  last completed snapshot, bit i = channel i value; disabled channels read 0
sample_valid  output  1  one-cycle pulse when sample updates
busy  output  1  high while a scan is in progress

Behaviour:
- Fixed interface decision: one clock, clk. Reset rst_n is asynchronous and active-low. All other logic is synchronous to the rising edge of clk.
- Reset values: sel=0, sample=0, sample_valid=0, busy=0, state=IDLE, settle counter=0, latched mask=0, shadow register=0.
- States: IDLE, SETTLE.
- IDLE:
  - On an edge with start=1 and en_mask!=0: latch en_mask into mask_q, clear shadow, set sel to the lowest enabled channel, cnt=0, busy=1, go to SETTLE.
  - start=1 with en_mask=0 is ignored: stays IDLE, no pulse.
- SETTLE, each edge:
  - If cnt < SETTLE_CYCLES-1: cnt++.
  - Else capture f_in into shadow[sel], then:
    - If a higher-numbered enabled channel remains in mask_q: sel to the next enabled channel, cnt=0, stay in SETTLE.
    - Otherwise (final capture): on the same edge, sample is set to the shadow value including this capture's bit, and sample_valid=1 for exactly one cycle.
      - continuous=1 and en_mask!=0: relatch mask, clear shadow, sel to the lowest enabled channel, cnt=0, stay in SETTLE, busy stays 1.
      - Otherwise: go to IDLE, busy=0, sel holds its last value.
- Timing: the 4:1 selector is combinational, so f_in reflects sel in the same cycle. Each enabled channel occupies exactly SETTLE_CYCLES cycles.
- Latency: with N enabled channels, sample_valid is high in the cycle after the edge occurring N*SETTLE_CYCLES edges after the start edge.
- Scan timing is unchanged by:
  - start while busy: ignored.
  - en_mask changes during a scan: no effect until the next scan start.
  - f_in changes before the capture edge: no effect.
- abort:
  - Has priority over everything except reset.
  - On an edge with abort=1 in SETTLE: go to IDLE, busy=0, sel=0, cnt=0, no sample_valid; sample keeps its previous snapshot.
  - In IDLE, abort has priority over start: no scan begins.
- Simultaneous final capture and abort: abort wins; no pulse, sample not updated.
- Reset mid-scan: immediate return to reset values, including sample=0.
- sample_valid is never high for two consecutive cycles. With continuous and N*SETTLE_CYCLES=1 (one channel, SETTLE_CYCLES=1) pulses recur every cycle; this case is explicitly allowed and treated as consecutive pulses of one cycle each.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle, no clock edge -> sel=0, sample=0, sample_valid=0, busy=0 immediately; same result when asserted mid-scan.
- Full scan, SETTLE_CYCLES=3, en_mask=4'b1111, mux model W0=1 W1=0 W2=1 W3=1, one-cycle start pulse -> sel sequence 0,1,2,3, each held 3 cycles; sample=4'b1101 with a single sample_valid pulse 12 edges after start; busy then 0.
- Sparse mask en_mask=4'b0101, same W -> sel visits only 0 then 2; sample=4'b0101, bits 1 and 3 forced 0; pulse after 6 edges.
- start with en_mask=0 -> busy stays 0, sel unchanged, no sample_valid; start while busy -> scan timing unchanged.
- Continuous with en_mask changed 4'b1111 to 4'b0010 mid-scan -> first scan still visits 0..3; second scan visits only channel 1, sample=4'b0000 with W1=0; drop continuous -> IDLE after the current scan.
- abort on channel 2 of a 4-channel scan -> next edge: IDLE, sel=0, busy=0, no pulse, sample retains the prior snapshot; abort coincident with the final capture -> no pulse.
